// File: rtl/swi_debounce.sv
// Switch-bank input conditioning: a two-flop synchronizer per bit, then a
// per-bit consecutive-sample debounce counter. Produces a clean switch vector,
// one-cycle rise/fall strobes, a combined change strobe and a busy flag.
module swi_debounce #(
  parameter int NBITS           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CW             = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic [NBITS-1:0] SWI,
  output logic [NBITS-1:0] stable_o,
  output logic [NBITS-1:0] rise_o,
  output logic [NBITS-1:0] fall_o,
  output logic             any_change_o,
  output logic             busy_o
);

  // Count value on which a differing sample is finally accepted.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [NBITS-1:0] sync1;
  logic [NBITS-1:0] sync2;
  logic [CW-1:0]    cnt     [NBITS];
  logic [CW-1:0]    cnt_nxt [NBITS];
  logic [NBITS-1:0] stable_nxt;
  logic [NBITS-1:0] rise_nxt;
  logic [NBITS-1:0] fall_nxt;
  logic             busy_nxt;

  // Two-stage synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= SWI;
      sync2 <= sync1;
    end
  end

  // Per-bit debounce decision: count differing samples, accept on the last one.
  always_comb begin
    stable_nxt = stable_o;
    rise_nxt   = '0;
    fall_nxt   = '0;
    busy_nxt   = 1'b0;
    for (int i = 0; i < NBITS; i++) begin
      cnt_nxt[i] = '0;
      if (sync2[i] != stable_o[i]) begin
        if (cnt[i] == CNT_LAST) begin
          stable_nxt[i] = sync2[i];
          rise_nxt[i]   = sync2[i];
          fall_nxt[i]   = ~sync2[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
          busy_nxt   = 1'b1;
        end
      end
    end
  end

  // Debounce state and registered strobes; reset discards any count in progress.
  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      for (int i = 0; i < NBITS; i++) begin
        cnt[i] <= '0;
      end
      stable_o     <= '0;
      rise_o       <= '0;
      fall_o       <= '0;
      any_change_o <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      for (int i = 0; i < NBITS; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      stable_o     <= stable_nxt;
      rise_o       <= rise_nxt;
      fall_o       <= fall_nxt;
      any_change_o <= |(rise_nxt | fall_nxt);
      busy_o       <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_swi_debounce.sv
// Self-checking bench for swi_debounce: a table of settle sequences, hand-written
// corner-case sequences, and randomized stimulus against a sliding-window model.
module tb_swi_debounce;

  localparam int NB  = 8;
  localparam int DEB = 4;

  logic          clk_2;
  logic          reset_n;
  logic [NB-1:0] SWI;
  logic [NB-1:0] stable_o;
  logic [NB-1:0] rise_o;
  logic [NB-1:0] fall_o;
  logic          any_change_o;
  logic          busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  swi_debounce #(.NBITS(NB), .DEBOUNCE_CYCLES(DEB)) dut (
    .clk_2        (clk_2),
    .reset_n      (reset_n),
    .SWI          (SWI),
    .stable_o     (stable_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .any_change_o (any_change_o),
    .busy_o       (busy_o)
  );

  // Free-running clock.
  initial begin
    clk_2 = 1'b0;
    forever #5 clk_2 = ~clk_2;
  end

  // Guard against a run that never finishes.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reference model: a bit is accepted once the last DEB synchronized samples
  // all differ from the current stable value. Synchronized samples are the raw
  // samples delayed by two edges since the last reset (zero before that).
  logic [NB-1:0] swi_q [$];
  logic [NB-1:0] d_q   [$];
  logic [NB-1:0] m_stable = '0;
  logic [NB-1:0] m_rise   = '0;
  logic [NB-1:0] m_fall   = '0;
  logic          m_any    = 1'b0;
  logic          m_busy   = 1'b0;

  task automatic model_edge(input logic rst_n, input logic [NB-1:0] swi);
    logic [NB-1:0] d;
    logic [NB-1:0] old;
    logic [NB-1:0] t;
    logic          all_diff;
    if (!rst_n) begin
      swi_q.delete();
      d_q.delete();
      m_stable = '0;
      m_rise   = '0;
      m_fall   = '0;
      m_any    = 1'b0;
      m_busy   = 1'b0;
    end else begin
      d = (swi_q.size() >= 2) ? swi_q[swi_q.size()-2] : '0;
      swi_q.push_back(swi);
      d_q.push_back(d);
      old = m_stable;
      for (int i = 0; i < NB; i++) begin
        if (d_q.size() >= DEB) begin
          all_diff = 1'b1;
          for (int k = 0; k < DEB; k++) begin
            t = d_q[d_q.size()-1-k];
            if (t[i] == old[i]) all_diff = 1'b0;
          end
          if (all_diff) m_stable[i] = ~old[i];
        end
      end
      m_rise = m_stable & ~old;
      m_fall = old & ~m_stable;
      m_any  = |(m_rise | m_fall);
      m_busy = |(d ^ m_stable);
      while (swi_q.size() > 2) void'(swi_q.pop_front());
      while (d_q.size() > DEB) void'(d_q.pop_front());
    end
  endtask

  // Drive inputs, take one edge, advance the model, sample just after the edge.
  task automatic applyStimulus(input logic rst_n, input logic [NB-1:0] swi);
    reset_n = rst_n;
    SWI     = swi;
    @(posedge clk_2);
    model_edge(rst_n, swi);
    #1;
  endtask

  task automatic cmp(input string name, input string sig,
                     input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s %s: got %0h expected %0h", name, sig, got, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [NB-1:0] e_stable,
                             input logic [NB-1:0] e_rise, input logic [NB-1:0] e_fall,
                             input logic e_any, input logic e_busy);
    cmp(name, "stable_o", 32'(stable_o), 32'(e_stable));
    cmp(name, "rise_o", 32'(rise_o), 32'(e_rise));
    cmp(name, "fall_o", 32'(fall_o), 32'(e_fall));
    cmp(name, "any_change_o", 32'(any_change_o), 32'(e_any));
    cmp(name, "busy_o", 32'(busy_o), 32'(e_busy));
  endtask

  typedef struct {
    logic          rst_n;
    logic [NB-1:0] swi;
    logic [NB-1:0] stable;
    logic [NB-1:0] rise;
    logic [NB-1:0] fall;
    logic          any;
    logic          busy;
  } vec_t;

  vec_t vecs [$];

  // Append the expected edge-by-edge response to a step from old_v to new_v held.
  function automatic void add_settle(input logic [NB-1:0] old_v, input logic [NB-1:0] new_v);
    vec_t v;
    for (int k = 1; k <= DEB + 3; k++) begin
      v.rst_n  = 1'b1;
      v.swi    = new_v;
      v.stable = (k >= DEB + 2) ? new_v : old_v;
      v.rise   = (k == DEB + 2) ? (new_v & ~old_v) : '0;
      v.fall   = (k == DEB + 2) ? (old_v & ~new_v) : '0;
      v.any    = (k == DEB + 2) && (old_v != new_v);
      v.busy   = (k >= 3) && (k <= DEB + 1) && (old_v != new_v);
      vecs.push_back(v);
    end
  endfunction

  // Main test sequence.
  initial begin
    vec_t          v;
    logic [NB-1:0] cur;
    int            seen;
    int            pulse_cnt;
    int            pulse_edge;
    int            hold;

    reset_n = 1'b0;
    SWI     = '0;

    for (int r = 0; r < 3; r++) begin
      v = '{rst_n: 1'b0, swi: 8'hFF, stable: '0, rise: '0, fall: '0, any: 1'b0, busy: 1'b0};
      vecs.push_back(v);
    end
    add_settle(8'h00, 8'hFF);
    add_settle(8'hFF, 8'h00);
    add_settle(8'h00, 8'h05);
    add_settle(8'h05, 8'h0F);
    add_settle(8'h0F, 8'hF0);

    for (int j = 0; j < vecs.size(); j++) begin
      applyStimulus(vecs[j].rst_n, vecs[j].swi);
      checkOutput($sformatf("vec%0d", j), vecs[j].stable, vecs[j].rise,
                  vecs[j].fall, vecs[j].any, vecs[j].busy);
    end

    // Glitch on bit 1 shorter than the debounce window.
    seen = 0;
    for (int k = 0; k < 3 + DEB + 4; k++) begin
      applyStimulus(1'b1, (k < 3) ? 8'hF2 : 8'hF0);
      checkOutput("glitch", m_stable, m_rise, m_fall, m_any, m_busy);
      if (rise_o[1] || fall_o[1]) seen++;
    end
    cmp("glitch", "stable_o[1]", 32'(stable_o[1]), 32'd0);
    cmp("glitch", "pulse_count", 32'(seen), 32'd0);
    cmp("glitch", "busy_o_end", 32'(busy_o), 32'd0);

    // Bounce on bit 2, then hold high: one rise pulse DEB+2 edges after settling.
    pulse_cnt  = 0;
    pulse_edge = 0;
    for (int k = 1; k <= 5 + DEB + 4; k++) begin
      cur = (k <= 5 && (k % 2 == 0)) ? 8'hF0 : 8'hF4;
      applyStimulus(1'b1, cur);
      checkOutput("bounce", m_stable, m_rise, m_fall, m_any, m_busy);
      if (rise_o[2]) begin
        pulse_cnt++;
        pulse_edge = k;
      end
    end
    cmp("bounce", "rise2_count", 32'(pulse_cnt), 32'd1);
    cmp("bounce", "rise2_edge", 32'(pulse_edge), 32'(5 + DEB + 1));

    // Reset in the middle of a count on bit 0.
    seen = 0;
    for (int k = 1; k <= 4; k++) begin
      applyStimulus((k == 4) ? 1'b0 : 1'b1, 8'hF5);
      checkOutput("rstmid_pre", m_stable, m_rise, m_fall, m_any, m_busy);
      if (rise_o[0] || any_change_o) seen++;
    end
    cmp("rstmid", "early_pulses", 32'(seen), 32'd0);
    pulse_edge = 0;
    for (int k = 1; k <= DEB + 4; k++) begin
      applyStimulus(1'b1, 8'hF5);
      checkOutput("rstmid_post", m_stable, m_rise, m_fall, m_any, m_busy);
      if (stable_o[0] && pulse_edge == 0) pulse_edge = k;
    end
    cmp("rstmid", "accept_edge", 32'(pulse_edge), 32'(DEB + 2));

    // Randomized stimulus: sparse bit changes, random hold lengths, rare resets.
    cur = 8'hF5;
    for (int n = 0; n < 80; n++) begin
      cur  = cur ^ NB'($urandom & $urandom & $urandom);
      hold = $urandom_range(1, DEB + 3);
      for (int h = 0; h < hold; h++) begin
        applyStimulus(($urandom_range(0, 63) != 0), cur);
        checkOutput("rand", m_stable, m_rise, m_fall, m_any, m_busy);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/swi_debounce.md
Name: swi_debounce

Overview:
Input-conditioning stage between the board switch bank SWI and the combinational logic it drives (the 2x1 mux on SWI[0..2], the LCD mirrors and LED logic). Each switch bit passes through a two-flop synchronizer, then a per-bit consecutive-sample debounce counter. The block outputs a clean, stable switch vector plus one-cycle rise/fall strobes. Downstream logic consumes stable_o in place of raw SWI.

Parameters:
NBITS, 8, width of switch vector (matches NBITS_TOP)
DEBOUNCE_CYCLES, 4, consecutive clk_2 cycles a synchronized bit must differ from its stable value before acceptance; legal range 1..255
CW, $clog2(DEBOUNCE_CYCLES+1), derived width of each per-bit counter; not overridden

Ports:
clk_2  input  1  single system clock; all state updates on its rising edge
reset_n  input  1  reset, synchronous, active-low
SWI  input  NBITS  raw asynchronous switch inputs
stable_o  output  NBITS  debounced switch vector
rise_o  output  NBITS  one-cycle pulse per bit on accepted 0->1
fall_o  output  NBITS  one-cycle pulse per bit on accepted 1->0
any_change_o  output  1  OR-reduction of (rise_o | fall_o), registered timing identical to rise/fall
busy_o  output  1  1 while any per-bit counter is nonzero

Behaviour:
- One clock, clk_2; reset is synchronous and active-low (reset_n sampled on rising edge of clk_2; no asynchronous paths).
- Reset (reset_n=0 at an edge): sync1, sync2, stable_o, all counters, rise_o, fall_o, any_change_o, busy_o all <= 0. Reset mid-count discards progress; no pulse emitted on the reset edge.
- Synchronizer: sync1 <= SWI; sync2 <= sync1. No logic between stages.
- Per bit i, each edge (reset_n=1):
  - sync2[i] == stable_o[i]: cnt[i] <= 0; no pulse.
  - sync2[i] != stable_o[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1; no pulse.
  - sync2[i] != stable_o[i] and cnt[i] == DEBOUNCE_CYCLES-1: stable_o[i] <= sync2[i]; cnt[i] <= 0; rise_o[i] <= sync2[i]; fall_o[i] <= ~sync2[i].
  - rise_o/fall_o otherwise <= 0 each edge: strictly one-cycle pulses, never both set for one bit.
- Latency: SWI[i] steps and holds; counting the first edge that samples the new value as edge 1, stable_o[i] and its pulse update on edge DEBOUNCE_CYCLES+2 (edge 6 at default).
- Glitch rejection: any return of sync2[i] to stable_o[i] before the count completes clears cnt[i]; stable_o[i] unchanged, no pulse. Counts restart from 0 on the next differing sample.
- Bits are fully independent; simultaneous acceptance on several bits yields simultaneous pulses; any_change_o single 1-cycle pulse.
- DEBOUNCE_CYCLES=1: accept on first differing sync2 sample (latency 3 edges); cnt never leaves 0.
- busy_o registered: busy_o <= 1 on any edge where some cnt is written nonzero; else 0.
- Counter never exceeds DEBOUNCE_CYCLES-1; no wrap-around possible.

Test Plan:
- Reset: hold reset_n=0 3 cycles with SWI=8'hFF -> all outputs 0; release -> stable_o=8'hFF on 6th edge after release, rise_o=8'hFF and any_change_o=1 for exactly that cycle, fall_o=0.
- Clean step: SWI 8'h00->8'h05 and held -> stable_o=8'h05 on edge 6, rise_o=8'h05 one cycle; busy_o=1 edges 3..5, 0 after.
- Glitch: SWI[1] high for 3 cycles then low -> stable_o[1] stays 0, no rise/fall pulse, busy_o returns 0.
- Bounce then settle: SWI[2] toggles 1,0,1,0,1 one cycle each then holds 1 -> single rise_o[2] pulse, DEBOUNCE_CYCLES+2 edges after final transition.
- Falling + simultaneous: from stable 8'h0F, SWI->8'hF0 -> stable_o=8'hF0 same edge; rise_o=8'hF0, fall_o=8'h0F, any_change_o one pulse.
- Reset mid-count: SWI[0] 0->1, assert reset_n=0 at edge 4 for 1 cycle -> no pulse; stable_o[0] becomes 1 six edges after release.
